// File: rtl/sbn_core.sv
// sbn_core: multicycle subtract-and-branch-if-negative engine with host load port.
// Define SBN_ICOUNT_EN to add a saturating retired-instruction counter output.
module sbn_core #(
  parameter int unsigned FWIDTH    = 8,
  parameter int unsigned DWIDTH    = 32,
  parameter bit          BRANCH_LE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  ld_we,
  input  logic                  ld_sel,
  input  logic [FWIDTH-1:0]     ld_addr,
  input  logic [4*FWIDTH-1:0]   ld_idata,
  input  logic [DWIDTH-1:0]     ld_ddata,
  output logic [2:0]            state,
  output logic [FWIDTH-1:0]     pc,
  output logic [DWIDTH-1:0]     a,
  output logic [DWIDTH-1:0]     b,
  output logic                  halted
`ifdef SBN_ICOUNT_EN
  ,
  output logic [31:0]           icount
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_FETCH = 3'b001,
    S_RDA   = 3'b010,
    S_RDB   = 3'b011,
    S_WR    = 3'b100,
    S_BR    = 3'b101,
    S_HALT  = 3'b111
  } state_e;

  state_e                state_q;
  logic [FWIDTH-1:0]     pc_q;
  logic [4*FWIDTH-1:0]   ir_q;
  logic [DWIDTH-1:0]     x_q, y_q;
  logic                  flag_q, halted_q;

  logic [4*FWIDTH-1:0]   imem_q [2**FWIDTH];
  logic [DWIDTH-1:0]     dmem_q [2**FWIDTH];

  logic [FWIDTH-1:0]     fa, fb, fc, fd;
  logic [DWIDTH-1:0]     diff_d;
  logic                  flag_d, host_ok;

  always_comb begin
    fa      = ir_q[4*FWIDTH-1:3*FWIDTH];
    fb      = ir_q[3*FWIDTH-1:2*FWIDTH];
    fc      = ir_q[2*FWIDTH-1:FWIDTH];
    fd      = ir_q[FWIDTH-1:0];
    diff_d  = x_q - y_q;
    flag_d  = diff_d[DWIDTH-1] | (BRANCH_LE && (diff_d == '0));
    host_ok = (state_q == S_IDLE) || (state_q == S_HALT);
  end

  // Reset blocks both the WR-state result write and host loads in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == S_WR)
        dmem_q[fc] <= diff_d;
      else if (ld_we && host_ok && ld_sel)
        dmem_q[ld_addr] <= ld_ddata;
      if (ld_we && host_ok && !ld_sel)
        imem_q[ld_addr] <= ld_idata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      flag_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE:  if (run) state_q <= S_FETCH;
        S_FETCH: begin
          ir_q    <= imem_q[pc_q];
          state_q <= S_RDA;
        end
        S_RDA: begin
          x_q     <= dmem_q[fa];
          state_q <= S_RDB;
        end
        S_RDB: begin
          y_q <= dmem_q[fb];
          if (fc == '1) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else begin
            state_q <= S_WR;
          end
        end
        S_WR: begin
          flag_q  <= flag_d;
          state_q <= S_BR;
        end
        S_BR: begin
          pc_q    <= flag_q ? fd : pc_q + FWIDTH'(1);
          state_q <= run ? S_FETCH : S_IDLE;
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef SBN_ICOUNT_EN
  logic [31:0] icnt_q;

  always_ff @(posedge clk) begin
    if (rst)
      icnt_q <= '0;
    else if (state_q == S_BR && icnt_q != '1)
      icnt_q <= icnt_q + 32'd1;
  end

  assign icount = icnt_q;
`endif

  assign state  = state_q;
  assign pc     = pc_q;
  assign a      = x_q;
  assign b      = y_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_sbn_core.sv
// Bench for sbn_core: two instances (SBN and SUBLEQ branch modes) driven in lockstep
// and compared against an instruction-level reference model.
module tb_sbn_core;

  logic        clk = 1'b0;
  logic        rst, run, ld_we, ld_sel;
  logic [7:0]  ld_addr;
  logic [31:0] ld_idata, ld_ddata;

  logic [2:0]  st  [2];
  logic [7:0]  pcv [2];
  logic [31:0] av  [2];
  logic [31:0] bv  [2];
  logic        hv  [2];
`ifdef SBN_ICOUNT_EN
  logic [31:0] icv [2];
`endif

  sbn_core #(.FWIDTH(8), .DWIDTH(32), .BRANCH_LE(1'b0)) u0 (
    .clk(clk), .rst(rst), .run(run), .ld_we(ld_we), .ld_sel(ld_sel),
    .ld_addr(ld_addr), .ld_idata(ld_idata), .ld_ddata(ld_ddata),
    .state(st[0]), .pc(pcv[0]), .a(av[0]), .b(bv[0]), .halted(hv[0])
`ifdef SBN_ICOUNT_EN
    , .icount(icv[0])
`endif
  );

  sbn_core #(.FWIDTH(8), .DWIDTH(32), .BRANCH_LE(1'b1)) u1 (
    .clk(clk), .rst(rst), .run(run), .ld_we(ld_we), .ld_sel(ld_sel),
    .ld_addr(ld_addr), .ld_idata(ld_idata), .ld_ddata(ld_ddata),
    .state(st[1]), .pc(pcv[1]), .a(av[1]), .b(bv[1]), .halted(hv[1])
`ifdef SBN_ICOUNT_EN
    , .icount(icv[1])
`endif
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model state, one copy per instance (k=1 is the SUBLEQ variant).
  logic [31:0] m_imem [256];
  logic [31:0] m_dmem [2][256];
  logic [7:0]  m_pc   [2];
  logic [31:0] m_a    [2];
  logic [31:0] m_b    [2];
  logic        m_halt [2];
  logic [7:0]  m_lastc[2];
  int unsigned m_cnt  [2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dut_dmem(input int k, input logic [7:0] ad);
    return (k == 0) ? u0.dmem_q[ad] : u1.dmem_q[ad];
  endfunction

  function automatic logic [31:0] dut_imem(input int k, input logic [7:0] ad);
    return (k == 0) ? u0.imem_q[ad] : u1.imem_q[ad];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 8'h00; m_a[k] = '0; m_b[k] = '0; m_halt[k] = 1'b0; m_cnt[k] = 0;
    end
  endtask

  task automatic model_step();
    logic [31:0] ins, res;
    logic [7:0]  fa, fb, fc, fd;
    for (int k = 0; k < 2; k++) begin
      if (!m_halt[k]) begin
        ins = m_imem[m_pc[k]];
        {fa, fb, fc, fd} = ins;
        m_a[k] = m_dmem[k][fa];
        m_b[k] = m_dmem[k][fb];
        m_lastc[k] = fc;
        if (fc == 8'hFF) begin
          m_halt[k] = 1'b1;
        end else begin
          res = m_a[k] - m_b[k];
          m_dmem[k][fc] = res;
          if ($signed(res) < 0 || (k == 1 && res == 0)) m_pc[k] = fd;
          else m_pc[k] = m_pc[k] + 8'd1;
          m_cnt[k]++;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s.state%0d", tag, k), 32'(st[k]), m_halt[k] ? 32'd7 : 32'd0);
      chk($sformatf("%s.pc%0d", tag, k), 32'(pcv[k]), 32'(m_pc[k]));
      chk($sformatf("%s.a%0d", tag, k), av[k], m_a[k]);
      chk($sformatf("%s.b%0d", tag, k), bv[k], m_b[k]);
      chk($sformatf("%s.halted%0d", tag, k), 32'(hv[k]), 32'(m_halt[k]));
      chk($sformatf("%s.dmem%0d[%0h]", tag, k, m_lastc[k]),
          dut_dmem(k, m_lastc[k]), m_dmem[k][m_lastc[k]]);
`ifdef SBN_ICOUNT_EN
      chk($sformatf("%s.icount%0d", tag, k), icv[k], m_cnt[k]);
`endif
    end
  endtask

  task automatic load_i(input logic [7:0] ad, input logic [31:0] d);
    ld_we = 1'b1; ld_sel = 1'b0; ld_addr = ad; ld_idata = d;
    tick();
    ld_we = 1'b0;
    m_imem[ad] = d;
  endtask

  task automatic load_d(input logic [7:0] ad, input logic [31:0] d);
    ld_we = 1'b1; ld_sel = 1'b1; ld_addr = ad; ld_ddata = d;
    tick();
    ld_we = 1'b0;
    m_dmem[0][ad] = d;
    m_dmem[1][ad] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic step(input string tag);
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (5) tick();
    model_step();
    check_all(tag);
  endtask

  initial begin
    logic [7:0] ra, rb, rc, rd;
    rst = 1'b1; run = 1'b0; ld_we = 1'b0; ld_sel = 1'b0;
    ld_addr = '0; ld_idata = '0; ld_ddata = '0;
    m_lastc[0] = 8'h0C; m_lastc[1] = 8'h0C;
    tick();
    rst = 1'b0;
    model_reset();

    load_i(8'h00, 32'h0A0B0C05);
    load_i(8'h01, 32'h0A0BFF00);
    load_i(8'h02, 32'h01020304);
    load_d(8'h0A, 32'd7);
    load_d(8'h0B, 32'd3);
    load_d(8'h0C, 32'h55);
    load_d(8'h0D, 32'h0);
    load_d(8'h30, 32'hCAFE0030);
    load_d(8'hFF, 32'hDEAD);

    // Reset held two cycles with run high, then FETCH one cycle after release.
    rst = 1'b1; run = 1'b1;
    tick(); tick();
    model_reset();
    check_all("reset");
    rst = 1'b0;
    tick();
    chk("fetch_after_rst0", 32'(st[0]), 32'd1);
    chk("fetch_after_rst1", 32'(st[1]), 32'd1);
    run = 1'b0;
    repeat (5) tick();
    model_step();
    check_all("nonbranch");

    load_d(8'h0A, 32'd3); load_d(8'h0B, 32'd7);
    do_reset();
    step("branch");

    load_d(8'h0A, 32'd5); load_d(8'h0B, 32'd5);
    do_reset();
    step("equal");

    load_d(8'h0A, 32'd7); load_d(8'h0B, 32'd3);
    do_reset();
    step("prehalt");
    step("halt");
    run = 1'b1;
    repeat (4) tick();
    run = 1'b0;
    check_all("halt_run_ignored");
    chk("halt_ff0", dut_dmem(0, 8'hFF), 32'hDEAD);
    chk("halt_ff1", dut_dmem(1, 8'hFF), 32'hDEAD);
    load_d(8'h20, 32'h1234);
    chk("halt_load0", dut_dmem(0, 8'h20), 32'h1234);
    chk("halt_load1", dut_dmem(1, 8'h20), 32'h1234);

    // pc+1 wrap from 0xFF to 0x00.
    do_reset();
    load_i(8'h00, 32'h0A0B0CFF);
    load_i(8'hFF, 32'h0B0A0D33);
    load_d(8'h0A, 32'd3); load_d(8'h0B, 32'd7);
    step("to_ff");
    step("wrap");

    // Host writes while executing must be dropped.
    do_reset();
    run = 1'b1; tick(); run = 1'b0;
    tick();
    chk("in_rda", 32'(st[0]), 32'd2);
    ld_we = 1'b1; ld_sel = 1'b1; ld_addr = 8'h30; ld_ddata = 32'hBAD0BAD0;
    tick();
    ld_sel = 1'b0; ld_addr = 8'h02; ld_idata = 32'hFFFFFFFF;
    tick();
    ld_we = 1'b0;
    repeat (3) tick();
    model_step();
    check_all("busy_load");
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("busy_dmem30_%0d", k), dut_dmem(k, 8'h30), 32'hCAFE0030);
      chk($sformatf("busy_imem02_%0d", k), dut_imem(k, 8'h02), 32'h01020304);
    end

    // Reset landing in WR suppresses the result write.
    do_reset();
    load_d(8'h0A, 32'd9); load_d(8'h0B, 32'd1); load_d(8'h0C, 32'h77);
    run = 1'b1; tick(); run = 1'b0;
    repeat (3) tick();
    chk("in_wr", 32'(st[0]), 32'd4);
    rst = 1'b1; tick(); rst = 1'b0;
    model_reset();
    m_lastc[0] = 8'h0C; m_lastc[1] = 8'h0C;
    check_all("rst_in_wr");

    // Randomized programs over a small data window.
    for (int i = 0; i < 16; i++) begin
      ra = 8'h40 + 8'($urandom_range(0, 15));
      rb = 8'h40 + 8'($urandom_range(0, 15));
      rc = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'h40 + 8'($urandom_range(0, 15));
      rd = 8'($urandom_range(0, 15));
      load_i(8'(i), {ra, rb, rc, rd});
    end
    load_i(8'h10, 32'h4041FF00);
    for (int i = 0; i < 16; i++)
      load_d(8'h40 + 8'(i), ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 3)) : $urandom);
    do_reset();
    for (int s = 0; s < 40; s++) begin
      if (m_halt[0] && m_halt[1]) do_reset();
      step($sformatf("rand%0d", s));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
